// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register: splits MUL/DIV results into Rd and R15 writeback slots,
// and traps ADD/SUB overflow and divide-by-zero until the handler acknowledges.
module ex_mem_stage #(
    parameter logic [3:0] R15_ADDR = 4'hF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic [3:0]  CTRL,
    input  logic [15:0] ALU_Result,
    input  logic [15:0] Remainder,
    input  logic        Overflow_flag,
    input  logic [15:0] op_b,
    input  logic [3:0]  ex_rd,
    input  logic        ex_reg_write,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic [15:0] ex_store_data,
    input  logic [15:0] ex_pc,
    input  logic        mem_stall,
    input  logic        exc_ack,
    output logic        mem_valid,
    output logic [3:0]  mem_rd,
    output logic        mem_reg_write,
    output logic        mem_mem_read,
    output logic        mem_mem_write,
    output logic [15:0] mem_result,
    output logic [15:0] mem_store_data,
    output logic        ex_stall,
    output logic        ex_flush,
    output logic        exc_valid,
    output logic [1:0]  exc_code,
    output logic [15:0] exc_pc
);

    localparam logic [3:0] CtrlAdd = 4'b1111;
    localparam logic [3:0] CtrlSub = 4'b1110;
    localparam logic [3:0] CtrlMul = 4'b0001;
    localparam logic [3:0] CtrlDiv = 4'b0010;

    typedef enum logic [1:0] {StRun, StSplit, StExc} state_e;

    state_e      state_q, state_d;
    logic [15:0] rem_q, rem_d;
    logic        valid_q, valid_d;
    logic [3:0]  rd_q, rd_d;
    logic        rw_q, rw_d;
    logic        mr_q, mr_d;
    logic        mw_q, mw_d;
    logic [15:0] result_q, result_d;
    logic [15:0] sd_q, sd_d;
    logic        exc_valid_q, exc_valid_d;
    logic [1:0]  exc_code_q, exc_code_d;
    logic [15:0] exc_pc_q, exc_pc_d;

    logic is_addsub, is_muldiv, ovf_fault, dz_fault;

    assign is_addsub = (CTRL == CtrlAdd) || (CTRL == CtrlSub);
    assign is_muldiv = (CTRL == CtrlMul) || (CTRL == CtrlDiv);
    assign ovf_fault = ex_valid && is_addsub && Overflow_flag;
    assign dz_fault  = ex_valid && (CTRL == CtrlDiv) && (op_b == 16'h0000);

    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        valid_d     = valid_q;
        rd_d        = rd_q;
        rw_d        = rw_q;
        mr_d        = mr_q;
        mw_d        = mw_q;
        result_d    = result_q;
        sd_d        = sd_q;
        exc_valid_d = exc_valid_q;
        exc_code_d  = exc_code_q;
        exc_pc_d    = exc_pc_q;

        unique case (state_q)
            StRun: begin
                if (!mem_stall) begin
                    if (ovf_fault || dz_fault) begin
                        // Faulting instruction becomes a bubble; nothing of it writes back.
                        valid_d     = 1'b0;
                        rd_d        = 4'h0;
                        rw_d        = 1'b0;
                        mr_d        = 1'b0;
                        mw_d        = 1'b0;
                        result_d    = 16'h0000;
                        sd_d        = 16'h0000;
                        exc_valid_d = 1'b1;
                        exc_code_d  = ovf_fault ? 2'b01 : 2'b10;
                        exc_pc_d    = ex_pc;
                        state_d     = StExc;
                    end else if (ex_valid && is_muldiv) begin
                        valid_d  = 1'b1;
                        rd_d     = ex_rd;
                        rw_d     = 1'b1;
                        mr_d     = 1'b0;
                        mw_d     = 1'b0;
                        result_d = ALU_Result;
                        sd_d     = ex_store_data;
                        rem_d    = Remainder;
                        state_d  = StSplit;
                    end else begin
                        valid_d  = ex_valid;
                        rd_d     = ex_rd;
                        rw_d     = ex_valid && ex_reg_write;
                        mr_d     = ex_valid && ex_mem_read;
                        mw_d     = ex_valid && ex_mem_write;
                        result_d = ALU_Result;
                        sd_d     = ex_store_data;
                    end
                end
            end
            StSplit: begin
                if (!mem_stall) begin
                    valid_d  = 1'b1;
                    rd_d     = R15_ADDR;
                    rw_d     = 1'b1;
                    mr_d     = 1'b0;
                    mw_d     = 1'b0;
                    result_d = rem_q;
                    sd_d     = 16'h0000;
                    state_d  = StRun;
                end
            end
            StExc: begin
                // Acknowledge is honoured even while MEM is stalled.
                if (exc_ack) begin
                    exc_valid_d = 1'b0;
                    state_d     = StRun;
                end
            end
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StRun;
            rem_q       <= 16'h0000;
            valid_q     <= 1'b0;
            rd_q        <= 4'h0;
            rw_q        <= 1'b0;
            mr_q        <= 1'b0;
            mw_q        <= 1'b0;
            result_q    <= 16'h0000;
            sd_q        <= 16'h0000;
            exc_valid_q <= 1'b0;
            exc_code_q  <= 2'b00;
            exc_pc_q    <= 16'h0000;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            valid_q     <= valid_d;
            rd_q        <= rd_d;
            rw_q        <= rw_d;
            mr_q        <= mr_d;
            mw_q        <= mw_d;
            result_q    <= result_d;
            sd_q        <= sd_d;
            exc_valid_q <= exc_valid_d;
            exc_code_q  <= exc_code_d;
            exc_pc_q    <= exc_pc_d;
        end
    end

    assign mem_valid      = valid_q;
    assign mem_rd         = rd_q;
    assign mem_reg_write  = rw_q;
    assign mem_mem_read   = mr_q;
    assign mem_mem_write  = mw_q;
    assign mem_result     = result_q;
    assign mem_store_data = sd_q;
    assign exc_valid      = exc_valid_q;
    assign exc_code       = exc_code_q;
    assign exc_pc         = exc_pc_q;
    assign ex_stall       = mem_stall || (state_q != StRun);
    assign ex_flush       = (state_q == StExc);

endmodule

// File: tb/tb_ex_mem_stage.sv
// Bench for ex_mem_stage: directed scenarios with literal expectations, then random
// stimulus compared every cycle against a slot/trap-level behavioural model.
module tb_ex_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        ex_valid = 1'b0;
    logic [3:0]  CTRL = 4'h0;
    logic [15:0] ALU_Result = 16'h0, Remainder = 16'h0, op_b = 16'h1;
    logic        Overflow_flag = 1'b0;
    logic [3:0]  ex_rd = 4'h0;
    logic        ex_reg_write = 1'b0, ex_mem_read = 1'b0, ex_mem_write = 1'b0;
    logic [15:0] ex_store_data = 16'h0, ex_pc = 16'h0;
    logic        mem_stall = 1'b0, exc_ack = 1'b0;
    logic        mem_valid, mem_reg_write, mem_mem_read, mem_mem_write;
    logic [3:0]  mem_rd;
    logic [15:0] mem_result, mem_store_data, exc_pc;
    logic        ex_stall, ex_flush, exc_valid;
    logic [1:0]  exc_code;

    int errors = 0;
    int checks = 0;
    bit started = 1'b0;

    ex_mem_stage dut (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .CTRL(CTRL),
        .ALU_Result(ALU_Result), .Remainder(Remainder), .Overflow_flag(Overflow_flag),
        .op_b(op_b), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_store_data(ex_store_data), .ex_pc(ex_pc),
        .mem_stall(mem_stall), .exc_ack(exc_ack), .mem_valid(mem_valid), .mem_rd(mem_rd),
        .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
        .mem_mem_write(mem_mem_write), .mem_result(mem_result),
        .mem_store_data(mem_store_data), .ex_stall(ex_stall), .ex_flush(ex_flush),
        .exc_valid(exc_valid), .exc_code(exc_code), .exc_pc(exc_pc)
    );

    always #5 clk = ~clk;

    // Model: what MEM currently holds, whether a trap is pending, and whether a
    // second (R15) writeback is still owed.
    typedef struct packed {
        logic        valid;
        logic [3:0]  rd;
        logic        rw, mr, mw;
        logic [15:0] res, sd;
        logic        ev;
        logic [1:0]  code;
        logic [15:0] epc;
        logic        owe_r15;
        logic [15:0] rem;
    } model_t;

    model_t m;

    function automatic model_t step(model_t cur);
        model_t n = cur;
        bit addsub = (CTRL == 4'hF) || (CTRL == 4'hE);
        bit ovf = ex_valid && addsub && Overflow_flag;
        bit dz = ex_valid && (CTRL == 4'h2) && (op_b == 16'h0);
        if (cur.ev) begin
            if (exc_ack) n.ev = 1'b0;
            return n;
        end
        if (mem_stall) return n;
        if (cur.owe_r15) begin
            n.valid = 1; n.rd = 4'hF; n.rw = 1; n.mr = 0; n.mw = 0;
            n.res = cur.rem; n.sd = 16'h0; n.owe_r15 = 0;
        end else if (ovf || dz) begin
            n = '0;
            n.ev = 1; n.code = ovf ? 2'b01 : 2'b10; n.epc = ex_pc;
        end else if (ex_valid && (CTRL == 4'h1 || CTRL == 4'h2)) begin
            n.valid = 1; n.rd = ex_rd; n.rw = 1; n.mr = 0; n.mw = 0;
            n.res = ALU_Result; n.sd = ex_store_data; n.owe_r15 = 1; n.rem = Remainder;
        end else begin
            n.valid = ex_valid; n.rd = ex_rd; n.rw = ex_valid & ex_reg_write;
            n.mr = ex_valid & ex_mem_read; n.mw = ex_valid & ex_mem_write;
            n.res = ALU_Result; n.sd = ex_store_data;
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= '0;
        else m <= step(m);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (started && rst_n) begin
            chk("m.valid", 32'(mem_valid), 32'(m.valid));
            chk("m.reg_write", 32'(mem_reg_write), 32'(m.rw));
            chk("m.mem_read", 32'(mem_mem_read), 32'(m.mr));
            chk("m.mem_write", 32'(mem_mem_write), 32'(m.mw));
            if (m.valid) begin
                chk("m.rd", 32'(mem_rd), 32'(m.rd));
                chk("m.result", 32'(mem_result), 32'(m.res));
            end
            if (m.valid && m.mw) chk("m.store_data", 32'(mem_store_data), 32'(m.sd));
            chk("m.exc_valid", 32'(exc_valid), 32'(m.ev));
            if (m.ev) begin
                chk("m.exc_code", 32'(exc_code), 32'(m.code));
                chk("m.exc_pc", 32'(exc_pc), 32'(m.epc));
            end
            chk("m.ex_flush", 32'(ex_flush), 32'(m.ev));
            chk("m.ex_stall", 32'(ex_stall), 32'(mem_stall | m.owe_r15 | m.ev));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_in(input logic v, input logic [3:0] c, input logic [15:0] res,
                          input logic [15:0] rem, input logic ovf, input logic [15:0] b,
                          input logic [3:0] rd, input logic [15:0] pc);
        ex_valid = v; CTRL = c; ALU_Result = res; Remainder = rem; Overflow_flag = ovf;
        op_b = b; ex_rd = rd; ex_pc = pc; ex_reg_write = 1'b1; ex_mem_read = 1'b0;
        ex_mem_write = 1'b0; ex_store_data = 16'h0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".valid"}, 32'(mem_valid), 0);
        chk({tag, ".rd"}, 32'(mem_rd), 0);
        chk({tag, ".rw"}, 32'(mem_reg_write), 0);
        chk({tag, ".result"}, 32'(mem_result), 0);
        chk({tag, ".exc_valid"}, 32'(exc_valid), 0);
        chk({tag, ".exc_code"}, 32'(exc_code), 0);
        chk({tag, ".exc_pc"}, 32'(exc_pc), 0);
        chk({tag, ".flush"}, 32'(ex_flush), 0);
        chk({tag, ".stall"}, 32'(ex_stall), 0);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #2 chk_all_zero("reset");
        #20 rst_n = 1'b1;
        started = 1'b1;
        tick();

        // ADD, one-cycle latency
        set_in(1, 4'hF, 16'h0007, 16'h0, 0, 16'h1, 4'd3, 16'h0010);
        tick();
        chk("add.valid", 32'(mem_valid), 1);
        chk("add.result", 32'(mem_result), 32'h7);
        chk("add.rd", 32'(mem_rd), 3);
        chk("add.stall", 32'(ex_stall), 0);

        // MUL split followed by ADD
        set_in(1, 4'h1, 16'h5678, 16'h1234, 0, 16'h3, 4'd2, 16'h0012);
        tick();
        chk("mul1.rd", 32'(mem_rd), 2);
        chk("mul1.result", 32'(mem_result), 32'h5678);
        chk("mul1.stall", 32'(ex_stall), 1);
        set_in(1, 4'hF, 16'h0009, 16'h0, 0, 16'h1, 4'd4, 16'h0014);
        tick();
        chk("mul2.rd", 32'(mem_rd), 15);
        chk("mul2.result", 32'(mem_result), 32'h1234);
        chk("mul2.rw", 32'(mem_reg_write), 1);
        chk("mul2.stall", 32'(ex_stall), 0);
        tick();
        chk("mul_next.rd", 32'(mem_rd), 4);
        chk("mul_next.result", 32'(mem_result), 32'h9);

        // Overflow trap held for 5 cycles
        set_in(1, 4'hF, 16'h8000, 16'h0, 1, 16'h1, 4'd5, 16'h0040);
        tick();
        chk("ovf.valid", 32'(mem_valid), 0);
        chk("ovf.exc_valid", 32'(exc_valid), 1);
        chk("ovf.code", 32'(exc_code), 1);
        chk("ovf.pc", 32'(exc_pc), 32'h40);
        set_in(1, 4'hF, 16'h0011, 16'h0, 0, 16'h1, 4'd6, 16'h0042);
        for (int i = 0; i < 4; i++) begin
            chk("ovf.flush", 32'(ex_flush), 1);
            tick();
            chk("ovf.hold_valid", 32'(mem_valid), 0);
        end
        chk("ovf.flush5", 32'(ex_flush), 1);
        exc_ack = 1'b1;
        tick();
        exc_ack = 1'b0;
        chk("ack.exc_valid", 32'(exc_valid), 0);
        chk("ack.flush", 32'(ex_flush), 0);
        tick();
        chk("resume.valid", 32'(mem_valid), 1);
        chk("resume.result", 32'(mem_result), 32'h11);

        // Divide by zero: trap, no split
        set_in(1, 4'h2, 16'hFFFF, 16'hAAAA, 0, 16'h0, 4'd7, 16'h0050);
        tick();
        chk("dz.code", 32'(exc_code), 2);
        chk("dz.pc", 32'(exc_pc), 32'h50);
        chk("dz.valid", 32'(mem_valid), 0);
        set_in(0, 4'h0, 16'h0, 16'h0, 0, 16'h1, 4'd0, 16'h0);
        tick();
        chk("dz.no_r15", 32'(mem_reg_write), 0);
        exc_ack = 1'b1;
        tick();
        exc_ack = 1'b0;

        // mem_stall during SPLIT
        set_in(1, 4'h1, 16'h0A0A, 16'h0B0B, 0, 16'h2, 4'd8, 16'h0060);
        tick();
        set_in(0, 4'h0, 16'h0, 16'h0, 0, 16'h1, 4'd0, 16'h0);
        mem_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall.result", 32'(mem_result), 32'h0A0A);
            chk("stall.rd", 32'(mem_rd), 8);
        end
        mem_stall = 1'b0;
        tick();
        chk("stall.slot2_rd", 32'(mem_rd), 15);
        chk("stall.slot2_res", 32'(mem_result), 32'h0B0B);

        // Async reset in SPLIT, then in EXC
        set_in(1, 4'h2, 16'h0003, 16'h0001, 0, 16'h5, 4'd9, 16'h0070);
        tick();
        set_in(0, 4'h0, 16'h0, 16'h0, 0, 16'h1, 4'd0, 16'h0);
        #1 rst_n = 1'b0;
        #1 chk_all_zero("rst_split");
        #1 rst_n = 1'b1;
        set_in(1, 4'hE, 16'h0001, 16'h0, 1, 16'h1, 4'd1, 16'h0080);
        tick();
        set_in(0, 4'h0, 16'h0, 16'h0, 0, 16'h1, 4'd0, 16'h0);
        #1 rst_n = 1'b0;
        #1 chk_all_zero("rst_exc");
        #1 rst_n = 1'b1;
        set_in(1, 4'hF, 16'h0022, 16'h0, 0, 16'h1, 4'd10, 16'h0090);
        tick();
        chk("post_rst.valid", 32'(mem_valid), 1);
        chk("post_rst.result", 32'(mem_result), 32'h22);
        chk("post_rst.rd", 32'(mem_rd), 10);

        // Random phase, checked every cycle against the model
        for (int i = 0; i < 3000; i++) begin
            int unsigned k;
            k = $urandom_range(0, 5);
            case (k)
                0: CTRL = 4'hF;
                1: CTRL = 4'hE;
                2: CTRL = 4'h1;
                3: CTRL = 4'h2;
                default: CTRL = 4'($urandom_range(3, 13));
            endcase
            ex_valid      = ($urandom_range(0, 3) != 0);
            ALU_Result    = 16'($urandom);
            Remainder     = 16'($urandom);
            Overflow_flag = ($urandom_range(0, 5) == 0);
            op_b          = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
            ex_rd         = 4'($urandom);
            ex_reg_write  = 1'($urandom);
            ex_mem_read   = 1'($urandom);
            ex_mem_write  = 1'($urandom);
            ex_store_data = 16'($urandom);
            ex_pc         = 16'($urandom);
            mem_stall     = ($urandom_range(0, 4) == 0);
            exc_ack       = ($urandom_range(0, 3) == 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ex_mem_stage.md
# ex_mem_stage

EX/MEM pipeline stage that registers the ALU outputs and control for the memory stage. It splits multiply/divide results into two register-file write slots: the low/quotient word goes to Rd, and the high/remainder word goes to R15. It also traps ADD/SUB overflow and divide-by-zero and holds the pipeline until the exception is acknowledged. It sits directly downstream of the ALU and feeds the MEM stage and the hazard/PC logic.

## Interface
- `R15_ADDR`, default 4'hF: register that receives Remainder for multiply/divide.
- `clk` — in, 1: single clock; all state updates on rising edge.
- `rst_n` — in, 1: asynchronous, active-low reset.
- `ex_valid` — in, 1: EX holds a real instruction.
- `CTRL` — in, 4: ALU opcode (1111 ADD, 1110 SUB, 0001 MUL, 0010 DIV, others single-result).
- `ALU_Result`, `Remainder` — in, 16 each: ALU outputs.
- `Overflow_flag` — in, 1: ALU overflow.
- `op_b` — in, 16: ALU bottom operand; divisor for the zero check.
- `ex_rd` — in, 4: destination register.
- `ex_reg_write`, `ex_mem_read`, `ex_mem_write` — in, 1 each: control bits.
- `ex_store_data` — in, 16: store data.
- `ex_pc` — in, 16: instruction PC.
- `mem_stall` — in, 1: MEM cannot accept; hold everything.
- `exc_ack` — in, 1: exception handler has taken the trap.
- `mem_valid`, `mem_rd`, `mem_reg_write`, `mem_mem_read`, `mem_mem_write`, `mem_result`, `mem_store_data` — out: registered stage contents.
- `ex_stall` — out, 1: EX must hold its instruction.
- `ex_flush` — out, 1: EX contents are discarded.
- `exc_valid` — out, 1, registered: exception pending.
- `exc_code` — out, 2: 01 overflow, 10 divide-by-zero.
- `exc_pc` — out, 16: PC of the faulting instruction.

## Operation
- States: `RUN`, `SPLIT`, `EXC`. Reset gives `RUN`, all outputs 0.
- Capture happens at an edge with `state==RUN`, `!mem_stall`, `!ex_flush`.
- **Fault check** (ADD/SUB with `Overflow_flag`, or DIV with `op_b==0`):
  - Load a bubble (`mem_valid=0`, all control 0).
  - Set `exc_valid=1` with the code and `ex_pc`, and go to `EXC`.
  - No writeback of any part of the faulting instruction.
- **MUL/DIV, no fault:**
  - Load slot 1: `mem_result=ALU_Result`, `mem_rd=ex_rd`, `reg_write=1`.
  - Save `Remainder` internally and go to `SPLIT`.
- **Otherwise:** load all fields directly; `mem_valid=ex_valid`.
- **Invalid input:** `ex_valid=0` loads a bubble; all control bits are forced 0 whenever `mem_valid=0`.
- **SPLIT:**
  - `ex_stall=1`.
  - At the next edge with `!mem_stall`, load slot 2: `mem_result=saved Remainder`, `mem_rd=R15_ADDR`, `reg_write=1`, mem_read/mem_write 0, `mem_valid=1`.
  - Return to `RUN`.
- **EXC:**
  - `ex_stall=1` and `ex_flush=1`; outputs hold the bubble.
  - On `exc_ack`: clear `exc_valid` and go to `RUN`.
  - `exc_ack` outside `EXC` is ignored.
- **`mem_stall`:** all registers and state hold in every state. `ex_stall=1` whenever `mem_stall=1`. The only exception is `exc_ack`, which is honoured in `EXC` regardless of `mem_stall`.
- **Combinational outputs:**
  - `ex_stall = mem_stall | (state!=RUN)`.
  - `ex_flush = (state==EXC)`.

## Timing
- Latency: 1 cycle EX→MEM for single-result instructions.
- MUL/DIV: Rd slot at N+1, R15 slot at N+2. `ex_stall` is high only during N+1, so the next EX instruction is captured at the end of N+2.
- Fault captured at edge N: `exc_valid` and `ex_flush` are high from N+1 until the edge after `exc_ack` is seen high.
- Reset mid-SPLIT or mid-EXC: the saved remainder is discarded, `exc_valid` is cleared, and the state returns to `RUN` immediately (asynchronous).
- A fault instruction is never followed by a SPLIT; the fault check has priority over the MUL/DIV split.

## Test plan
- **ADD:** ADD, ALU_Result=0x0007, rd=3 → next cycle `mem_valid=1`, `mem_result=0x0007`, `mem_rd=3`, `ex_stall=0`.
- **MUL split:** MUL, ALU_Result=0x5678, Remainder=0x1234, rd=2 → cycle +1: rd=2 / 0x5678, `ex_stall=1`; cycle +2: rd=15 / 0x1234, `ex_stall=0`; following ADD appears at +3.
- **Overflow trap:** ADD, Overflow_flag=1, pc=0x0040 → bubble, `exc_valid=1`, `exc_code=01`, `exc_pc=0x0040`. `ex_flush` stays high for 5 cycles until `exc_ack` is pulsed, then normal capture resumes.
- **Divide by zero:** DIV with `op_b=0` → `exc_code=10`, no R15 write, no SPLIT.
- **mem_stall in SPLIT:** `mem_stall` held 3 cycles during SPLIT → slot 1 outputs frozen; slot 2 appears the cycle after the stall drops.
- **Async reset:** `rst_n` asserted asynchronously during SPLIT and again during EXC → all outputs 0 immediately; after release, the first ADD passes with 1-cycle latency.
